// File: rtl/uart_peripheral.sv
// Memory-mapped UART: TX/RX byte FIFOs, 8N1 framing and sticky status flags.
// Each accepted bus request is answered by a one-cycle response on the next clock.
module uart_peripheral #(
  parameter int CLOCK_FREQ  = 25000000,
  parameter int BIT_RATE    = 9600,
  parameter int BUFFER_SIZE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  input  logic        rx,
  output logic        tx
);
  localparam int CPB  = CLOCK_FREQ / BIT_RATE;
  localparam int AW   = $clog2(BUFFER_SIZE);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0]   BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]   TICK0    = CW'(0);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(BUFFER_SIZE);
  localparam logic [CNTW-1:0] CNT0     = CNTW'(0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_e;

  logic            resp_q, resp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [7:0]      tx_mem_q [BUFFER_SIZE];
  logic [7:0]      rx_mem_q [BUFFER_SIZE];
  logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNTW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic            tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, ferr_q, ferr_d;
  state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]   tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
  logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic            tx_q, tx_d;
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;

  logic        accept_s, wr_s, rd_s, sts_wr_s;
  logic        tx_push_s, tx_pop_s, tx_push_ok_s, tx_full_s;
  logic        rx_push_s, rx_pop_s, rx_push_ok_s, rx_full_s, ferr_set_s, rx_fall_s;
  logic [31:0] status_s, rmux_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{address[31:4], address[1:0], write_data[31:8]};
  assign response  = resp_q;
  assign read_data = rdata_q;
  assign tx        = tx_q;

  // Bus decode and read-data mux; status reflects pre-update state.
  always_comb begin
    accept_s  = (read | write) & ~resp_q;
    wr_s      = accept_s & write;
    rd_s      = accept_s & ~write;
    tx_push_s = wr_s & (address[3:2] == 2'd0);
    sts_wr_s  = wr_s & (address[3:2] == 2'd2);
    rx_pop_s  = rd_s & (address[3:2] == 2'd1) & (rx_cnt_q != CNT0);
    tx_full_s = (tx_cnt_q == DEPTH);
    rx_full_s = (rx_cnt_q == DEPTH);
    status_s  = {24'd0, tx_state_q != S_IDLE, tx_ovf_q, ferr_q, rx_ovr_q,
                 rx_full_s, rx_cnt_q == CNT0, tx_cnt_q == CNT0, tx_full_s};
    case (address[3:2])
      2'd1:    rmux_s = (rx_cnt_q != CNT0) ? {24'd0, rx_mem_q[rx_rptr_q]} : 32'd0;
      2'd2:    rmux_s = status_s;
      default: rmux_s = 32'd0;
    endcase
    resp_d  = accept_s;
    rdata_d = rd_s ? rmux_s : 32'd0;
  end

  // FIFO bookkeeping and sticky flags; a pop frees the slot for a same-cycle push.
  always_comb begin
    tx_push_ok_s = tx_push_s & (~tx_full_s | tx_pop_s);
    rx_push_ok_s = rx_push_s & (~rx_full_s | rx_pop_s);
    tx_wptr_d = tx_push_ok_s ? tx_wptr_q + AW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop_s ? tx_rptr_q + AW'(1) : tx_rptr_q;
    rx_wptr_d = rx_push_ok_s ? rx_wptr_q + AW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop_s ? rx_rptr_q + AW'(1) : rx_rptr_q;
    tx_cnt_d  = tx_cnt_q + CNTW'(tx_push_ok_s) - CNTW'(tx_pop_s);
    rx_cnt_d  = rx_cnt_q + CNTW'(rx_push_ok_s) - CNTW'(rx_pop_s);
    tx_ovf_d  = (tx_push_s & ~tx_push_ok_s) | (tx_ovf_q & ~(sts_wr_s & write_data[6]));
    rx_ovr_d  = (rx_push_s & ~rx_push_ok_s) | (rx_ovr_q & ~(sts_wr_s & write_data[4]));
    ferr_d    = ferr_set_s | (ferr_q & ~(sts_wr_s & write_data[5]));
  end

  // TX framer; the line level is derived from the next state so it aligns with it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop_s   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_tick_d = TICK0;
        if (tx_cnt_q != CNT0) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_mem_q[tx_rptr_q];
          tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_tick_q == BIT_END) begin
          tx_tick_d  = TICK0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (tx_tick_q == BIT_END) begin
          tx_tick_d  = TICK0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_state_d = (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
        end else begin
          tx_state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tx_tick_q == BIT_END) begin
          tx_tick_d = TICK0;
          if (tx_cnt_q != CNT0) begin
            tx_pop_s   = 1'b1;
            tx_shift_d = tx_mem_q[tx_rptr_q];
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_state_d = S_STOP;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX deframer: start bit is checked at its mid-point, later samples one bit apart.
  always_comb begin
    rx_fall_s  = rx_prev_q & ~rx_sync2_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_tick_d  = TICK0;
        rx_state_d = rx_fall_s ? S_START : S_IDLE;
      end
      S_START: begin
        if (rx_tick_q == HALF_END) begin
          rx_tick_d  = TICK0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (rx_tick_q == BIT_END) begin
          rx_tick_d  = TICK0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (rx_tick_q == BIT_END) begin
          rx_tick_d  = TICK0;
          rx_push_s  = rx_sync2_q;
          ferr_set_s = ~rx_sync2_q;
          rx_state_d = S_IDLE;
        end else begin
          rx_state_d = S_STOP;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (tx_push_ok_s) tx_mem_q[tx_wptr_q] <= write_data[7:0];
    if (rx_push_ok_s) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  // State registers, including the rx synchronizer held at idle level in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
      tx_wptr_q  <= AW'(0);
      tx_rptr_q  <= AW'(0);
      rx_wptr_q  <= AW'(0);
      rx_rptr_q  <= AW'(0);
      tx_cnt_q   <= CNT0;
      rx_cnt_q   <= CNT0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= S_IDLE;
      rx_state_q <= S_IDLE;
      tx_tick_q  <= TICK0;
      rx_tick_q  <= TICK0;
      tx_bit_q   <= 3'd0;
      rx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      rx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_tick_q  <= tx_tick_d;
      rx_tick_q  <= rx_tick_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_q       <= tx_d;
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end
endmodule
